cfo_estimator: RTL and testbench

Frequency-offset estimator downstream of the PSS correlator/peak detector in the sync chain. On a detected peak it takes the two half-length partial correlations C0/C1 and forms P = C1·conj(C0). It then computes angle(P) with an iterative CORDIC and converts it to a per-sample phase increment. That increment is consumed by the DDS phase accumulator ahead of the complex mixer.

---
 rtl/cfo_estimator.sv | 224 ++++++++++++++++++++++
 tb/tb_cfo_estimator.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cfo_estimator.sv
// Carrier frequency offset estimator: angle(C1*conj(C0)) by iterative CORDIC,
// converted to a DDS phase increment that cancels the measured offset.
module cfo_estimator #(
  parameter int C_DW         = 64,
  parameter int PSS_LEN      = 128,
  parameter int CORDIC_DW    = 24,
  parameter int ATAN_DW      = 16,
  parameter int ITERATIONS   = 16,
  parameter int DDS_PHASE_DW = 20
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [C_DW-1:0]         C0_i,
  input  logic [C_DW-1:0]         C1_i,
  input  logic                    valid_i,
  output logic [ATAN_DW-1:0]      angle_o,
  output logic [DDS_PHASE_DW-1:0] phase_inc_o,
  output logic                    valid_o,
  output logic                    busy_o
);

  localparam int HW  = C_DW / 2;
  localparam int PW  = C_DW + 1;
  localparam int XW  = CORDIC_DW + 2;
  localparam int GW  = 4;
  localparam int ZW  = ATAN_DW + GW;
  localparam int SW  = $clog2(PW);
  localparam int IW  = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;
  localparam int PSH = $clog2(PSS_LEN) - 1;
  localparam int DSH = DDS_PHASE_DW - ATAN_DW;

  localparam logic [ZW-1:0] Z_PI  = {1'b1, {(ZW-1){1'b0}}};
  localparam logic [ZW-1:0] Z_RND = ZW'(32'd1) << (GW - 1);
  localparam logic [IW-1:0] LAST  = IW'(ITERATIONS - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_NORM = 3'd2,
    ST_ROT  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  function automatic logic [SW-1:0] redundant_sign_bits(input logic signed [PW-1:0] v);
    logic [SW-1:0] n;
    logic          run;
    n   = '0;
    run = 1'b1;
    for (int k = PW - 2; k >= 0; k--) begin
      if (run && (v[k] == v[PW-1])) begin
        n = n + SW'(1'b1);
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  // z carries GW guard bits so the rounded table entries do not accumulate
  // into the output; entries are atan(2^-i) scaled to 2^ZW = 2*pi at ZW=20.
  function automatic logic [ZW-1:0] atan_lut(input logic [IW-1:0] i);
    int unsigned idx;
    idx = 32'(i);
    case (idx)
      32'd0:   return ZW'(32'd131072);
      32'd1:   return ZW'(32'd77376);
      32'd2:   return ZW'(32'd40884);
      32'd3:   return ZW'(32'd20753);
      32'd4:   return ZW'(32'd10417);
      32'd5:   return ZW'(32'd5213);
      32'd6:   return ZW'(32'd2607);
      32'd7:   return ZW'(32'd1304);
      32'd8:   return ZW'(32'd652);
      32'd9:   return ZW'(32'd326);
      32'd10:  return ZW'(32'd163);
      32'd11:  return ZW'(32'd81);
      32'd12:  return ZW'(32'd41);
      32'd13:  return ZW'(32'd20);
      32'd14:  return ZW'(32'd10);
      32'd15:  return ZW'(32'd5);
      default: return ZW'(32'd0);
    endcase
  endfunction

  state_t                  state_r;
  logic [C_DW-1:0]         c0_r, c1_r;
  logic signed [PW-1:0]    pr_r, pi_r;
  logic signed [XW-1:0]    x_r, y_r;
  logic [ZW-1:0]           z_r;
  logic                    zero_r;
  logic [IW-1:0]           iter_r;

  logic signed [HW-1:0]    c0r_s, c0i_s, c1r_s, c1i_s;
  logic signed [PW-1:0]    c0r_x_s, c0i_x_s, c1r_x_s, c1i_x_s;
  logic signed [PW-1:0]    pr_s, pi_s;
  logic [SW-1:0]           sh_r_s, sh_i_s, sh_s;
  logic signed [PW-1:0]    prn_s, pin_s;
  logic signed [XW-1:0]    xn_s, yn_s;
  logic signed [XW-1:0]    xs_s, ys_s;
  logic [ZW-1:0]           at_s;
  logic [ZW-1:0]           z_rnd_s;
  logic signed [ATAN_DW-1:0]      ang_s;
  logic signed [DDS_PHASE_DW-1:0] ext_s, inc_s;

  assign c0r_s   = c0_r[HW-1:0];
  assign c0i_s   = c0_r[C_DW-1:HW];
  assign c1r_s   = c1_r[HW-1:0];
  assign c1i_s   = c1_r[C_DW-1:HW];
  assign c0r_x_s = PW'(c0r_s);
  assign c0i_x_s = PW'(c0i_s);
  assign c1r_x_s = PW'(c1r_s);
  assign c1i_x_s = PW'(c1i_s);
  assign pr_s    = c1r_x_s * c0r_x_s + c1i_x_s * c0i_x_s;
  assign pi_s    = c1i_x_s * c0r_x_s - c1r_x_s * c0i_x_s;

  // Common left shift keeps the Pr/Pi ratio; the top CORDIC_DW bits land
  // sign-extended in the low bits after the arithmetic right shift.
  assign sh_r_s  = redundant_sign_bits(pr_r);
  assign sh_i_s  = redundant_sign_bits(pi_r);
  assign sh_s    = (sh_r_s < sh_i_s) ? sh_r_s : sh_i_s;
  assign prn_s   = (pr_r <<< sh_s) >>> (PW - CORDIC_DW);
  assign pin_s   = (pi_r <<< sh_s) >>> (PW - CORDIC_DW);
  assign xn_s    = XW'(prn_s);
  assign yn_s    = XW'(pin_s);

  assign xs_s    = x_r >>> iter_r;
  assign ys_s    = y_r >>> iter_r;
  assign at_s    = atan_lut(iter_r);

  assign z_rnd_s = z_r + Z_RND;
  assign ang_s   = zero_r ? {ATAN_DW{1'b0}} : ATAN_DW'(z_rnd_s >> GW);
  assign ext_s   = DDS_PHASE_DW'(ang_s) <<< DSH;
  assign inc_s   = -(ext_s >>> PSH);

  // Estimation sequencer with registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r     <= ST_IDLE;
      c0_r        <= '0;
      c1_r        <= '0;
      pr_r        <= '0;
      pi_r        <= '0;
      x_r         <= '0;
      y_r         <= '0;
      z_r         <= '0;
      zero_r      <= 1'b0;
      iter_r      <= '0;
      angle_o     <= '0;
      phase_inc_o <= '0;
      valid_o     <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_i) begin
            c0_r    <= C0_i;
            c1_r    <= C1_i;
            busy_o  <= 1'b1;
            state_r <= ST_MULT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MULT: begin
          pr_r    <= pr_s;
          pi_r    <= pi_s;
          state_r <= ST_NORM;
        end
        ST_NORM: begin
          if (xn_s[XW-1]) begin
            x_r <= -xn_s;
            y_r <= -yn_s;
            z_r <= Z_PI;
          end else begin
            x_r <= xn_s;
            y_r <= yn_s;
            z_r <= '0;
          end
          zero_r  <= (pr_r == '0) && (pi_r == '0);
          iter_r  <= '0;
          state_r <= ST_ROT;
        end
        ST_ROT: begin
          if (!y_r[XW-1]) begin
            x_r <= x_r + ys_s;
            y_r <= y_r - xs_s;
            z_r <= z_r + at_s;
          end else begin
            x_r <= x_r - ys_s;
            y_r <= y_r + xs_s;
            z_r <= z_r - at_s;
          end
          iter_r <= iter_r + IW'(1'b1);
          if (iter_r == LAST) begin
            busy_o  <= 1'b0;
            state_r <= ST_OUT;
          end else begin
            state_r <= ST_ROT;
          end
        end
        ST_OUT: begin
          angle_o     <= ang_s;
          phase_inc_o <= inc_s;
          valid_o     <= 1'b1;
          // Accepting here gives the back-to-back period of ITERATIONS+3.
          if (valid_i) begin
            c0_r    <= C0_i;
            c1_r    <= C1_i;
            busy_o  <= 1'b1;
            state_r <= ST_MULT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_o  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfo_estimator.sv
// Self-checking bench for cfo_estimator: directed table, random vectors
// against a floating-point atan2 model, back-to-back stream and reset abort.
module tb_cfo_estimator;

  localparam real PI = 3.14159265358979323846;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic [63:0] c0_s, c1_s;
  logic        valid_i;
  logic [15:0] angle_o;
  logic [19:0] phase_inc_o;
  logic        valid_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  cfo_estimator dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .C0_i        (c0_s),
    .C1_i        (c1_s),
    .valid_i     (valid_i),
    .angle_o     (angle_o),
    .phase_inc_o (phase_inc_o),
    .valid_o     (valid_o),
    .busy_o      (busy_o)
  );

  typedef struct {
    logic [63:0] c0;
    logic [63:0] c1;
    int          ang;
    int          inc;
    int          inc_alt;
    int          tol;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit near(input real act, input real exp, input real modv, input real tol);
    real d;
    d = act - exp;
    while (d >= modv / 2.0) d = d - modv;
    while (d < -modv / 2.0) d = d + modv;
    return (d <= tol) && (d >= -tol);
  endfunction

  // Angle of C1*conj(C0) in units of 2*pi/65536, from exact integer products.
  function automatic real model_angle(input logic [63:0] c0, input logic [63:0] c1, output bit zero);
    longint ar, ai, br, bi, pr, pim;
    ar   = longint'($signed(c0[31:0]));
    ai   = longint'($signed(c0[63:32]));
    br   = longint'($signed(c1[31:0]));
    bi   = longint'($signed(c1[63:32]));
    pr   = br * ar + bi * ai;
    pim  = bi * ar - br * ai;
    zero = (pr == 0) && (pim == 0);
    if (zero) return 0.0;
    return $atan2(real'(pim), real'(pr)) * 65536.0 / (2.0 * PI);
  endfunction

  function automatic logic [31:0] rnd_comp(input int k);
    int unsigned base, mag;
    logic [31:0] v;
    base = 32'd1 << (k - 1);
    mag  = base + ($urandom % base);
    v    = mag;
    if ($urandom_range(1, 0) == 1) v = -v;
    return v;
  endfunction

  function automatic logic [63:0] rnd_c();
    int k;
    k = $urandom_range(30, 5);
    return {rnd_comp(k), rnd_comp(k)};
  endfunction

  // Isolated estimate: checks latency, busy length and pulse shape.
  task automatic run_one(input string tag, input logic [63:0] c0, input logic [63:0] c1,
                         output logic [15:0] ang, output logic [19:0] inc);
    int lat, bcnt;
    c0_s = c0; c1_s = c1; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 0; bcnt = 0;
    while (!valid_o && lat < 40) begin
      if (busy_o) bcnt++;
      @(posedge clk_i); #1;
      lat++;
    end
    ang = angle_o;
    inc = phase_inc_o;
    chk($sformatf("%s latency", tag), lat == 19, lat, 19);
    chk($sformatf("%s busy_cycles", tag), bcnt == 18, bcnt, 18);
    chk($sformatf("%s busy_at_valid", tag), busy_o == 1'b0, busy_o, 0);
    @(posedge clk_i); #1;
    chk($sformatf("%s valid_pulse", tag), valid_o == 1'b0, valid_o, 0);
  endtask

  task automatic check_model(input string tag, input logic [63:0] c0, input logic [63:0] c1,
                             input logic [15:0] ang, input logic [19:0] inc);
    real u, e;
    bit  z, ok;
    u = model_angle(c0, c1, z);
    if (z) begin
      chk($sformatf("%s angle", tag), ang == 16'h0000, ang, 0);
      chk($sformatf("%s phase_inc", tag), inc == 20'h00000, inc, 0);
    end else begin
      chk($sformatf("%s angle", tag), near(real'(ang), u, 65536.0, 2.0), ang, $rtoi(u));
      e  = -u / 4.0;
      ok = near(real'(inc), e, 1048576.0, 2.0);
      if (u > 32760.0)  ok = ok || near(real'(inc), e + 16384.0, 1048576.0, 2.0);
      if (u < -32760.0) ok = ok || near(real'(inc), e - 16384.0, 1048576.0, 2.0);
      chk($sformatf("%s phase_inc", tag), ok, inc, $rtoi(e));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] ang;
    logic [19:0] inc;
    logic [63:0] a, b;
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    bit          exp_busy, exp_valid, seen;

    reset_ni = 1'b0; valid_i = 1'b0; c0_s = '0; c1_s = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset angle", angle_o == 16'h0000, angle_o, 0);
    chk("reset phase_inc", phase_inc_o == 20'h00000, phase_inc_o, 0);
    chk("reset valid", valid_o == 1'b0, valid_o, 0);
    chk("reset busy", busy_o == 1'b0, busy_o, 0);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;

    vecs[0] = '{c0: {32'd0, 32'd1000}, c1: {32'd1000, 32'd0},
                ang: 32'h4000, inc: 32'hFF000, inc_alt: 32'hFF000, tol: 2};
    vecs[1] = '{c0: {32'd1000, 32'd0}, c1: {32'd0, 32'd1000},
                ang: 32'hC000, inc: 32'h01000, inc_alt: 32'h01000, tol: 2};
    vecs[2] = '{c0: {32'd0, 32'd1000}, c1: {32'd0, 32'hFFFFFC18},
                ang: 32'h8000, inc: 32'h02000, inc_alt: 32'hFE000, tol: 2};
    vecs[3] = '{c0: {32'd0, 32'h7FFFFFFF}, c1: {32'h7FFFFFFF, 32'h7FFFFFFF},
                ang: 32'h2000, inc: 32'hFF800, inc_alt: 32'hFF800, tol: 2};
    vecs[4] = '{c0: {32'd0, 32'd3}, c1: {32'd3, 32'd0},
                ang: 32'h4000, inc: 32'hFF000, inc_alt: 32'hFF000, tol: 2};
    vecs[5] = '{c0: 64'd0, c1: {32'hFFFFFCF7, 32'd12345},
                ang: 32'h0000, inc: 32'h00000, inc_alt: 32'h00000, tol: 0};

    for (int i = 0; i < 6; i++) begin
      run_one($sformatf("vec%0d", i), vecs[i].c0, vecs[i].c1, ang, inc);
      chk($sformatf("vec%0d angle", i),
          near(real'(ang), real'(vecs[i].ang), 65536.0, real'(vecs[i].tol)), ang, vecs[i].ang);
      chk($sformatf("vec%0d phase_inc", i),
          near(real'(inc), real'(vecs[i].inc), 1048576.0, real'(vecs[i].tol)) ||
          near(real'(inc), real'(vecs[i].inc_alt), 1048576.0, real'(vecs[i].tol)), inc, vecs[i].inc);
    end

    for (int i = 0; i < 30; i++) begin
      a = rnd_c();
      b = rnd_c();
      run_one($sformatf("rnd%0d", i), a, b, ang, inc);
      check_model($sformatf("rnd%0d", i), a, b, ang, inc);
    end

    // valid_i held high: only samples taken while idle are estimated.
    for (int t = 0; t < 85; t++) begin
      a = rnd_c();
      b = rnd_c();
      c0_s = a; c1_s = b;
      valid_i = (t < 60);
      if (t < 60 && (t % 19) == 0) begin
        q0.push_back(a);
        q1.push_back(b);
      end
      exp_busy = (t >= 1) && (t <= 75) && ((t % 19) != 0);
      chk($sformatf("b2b busy t=%0d", t), busy_o == exp_busy, busy_o, exp_busy);
      @(posedge clk_i); #1;
      exp_valid = (t >= 19) && (((t - 19) % 19) == 0) && ((t - 19) <= 57);
      chk($sformatf("b2b valid t=%0d", t), valid_o == exp_valid, valid_o, exp_valid);
      if (valid_o && exp_valid) begin
        if (q0.size() > 0) begin
          check_model($sformatf("b2b t=%0d", t), q0.pop_front(), q1.pop_front(), angle_o, phase_inc_o);
        end else begin
          chk($sformatf("b2b queue t=%0d", t), 1'b0, 0, 1);
        end
      end
    end
    chk("b2b leftover", q0.size() == 0, q0.size(), 0);
    valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset sampled on the edge that would perform ROT iteration 5.
    run_one("pre_reset", vecs[0].c0, vecs[0].c1, ang, inc);
    c0_s = vecs[1].c0; c1_s = vecs[1].c1; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (7) begin
      @(posedge clk_i); #1;
    end
    reset_ni = 1'b0;
    @(posedge clk_i); #1;
    reset_ni = 1'b1;
    chk("abort angle", angle_o == 16'h0000, angle_o, 0);
    chk("abort phase_inc", phase_inc_o == 20'h00000, phase_inc_o, 0);
    chk("abort valid", valid_o == 1'b0, valid_o, 0);
    chk("abort busy", busy_o == 1'b0, busy_o, 0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk_i); #1;
      if (valid_o || busy_o) seen = 1'b1;
    end
    chk("abort no_valid", seen == 1'b0, seen, 0);
    run_one("post_reset", vecs[1].c0, vecs[1].c1, ang, inc);
    chk("post_reset angle", near(real'(ang), real'(vecs[1].ang), 65536.0, 2.0), ang, vecs[1].ang);
    chk("post_reset phase_inc", near(real'(inc), real'(vecs[1].inc), 1048576.0, 2.0), inc, vecs[1].inc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
